// File: rtl/alu_serial_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_arb
// Description : Two-requester round-robin arbiter in front of a bit-serial
//               ALU. The granted operands are streamed LSB-first through an
//               external 1-bit ALU slice over W cycles. The per-bit results,
//               the OR of all carries and the MSB N flag are collected and
//               presented with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_arb #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic [1:0]   op0,
    input  logic [1:0]   op1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         done,
    output logic         done_id,
    output logic [W-1:0] result,
    output logic         carry_any,
    output logic         neg,
    output logic         slice_a,
    output logic         slice_b,
    output logic         slice_alucon0,
    output logic         slice_alucon,
    input  logic         slice_r,
    input  logic         slice_carry,
    input  logic         slice_n
);

    localparam int              KW       = $clog2(W);
    localparam logic [KW-1:0]   c_K_LAST = KW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic            id_q, id_d;
    logic            ptr_q, ptr_d;          // requester that wins a tie
    logic [W-1:0]    res_q, res_d;
    logic            cacc_q, cacc_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_any_q, carry_any_d;
    logic            neg_q, neg_d;
    logic            done_id_q, done_id_d;

    logic            w_grant;
    logic            w_pick1;

    // Arbitration: a grant happens only from IDLE and never while reset is high
    assign w_pick1 = req1 && (!req0 || ptr_q);
    assign w_grant = (state_q == S_IDLE) && (req0 || req1) && !rst;

    assign gnt0      = w_grant && !w_pick1;
    assign gnt1      = w_grant &&  w_pick1;
    assign busy      = w_grant || (state_q != S_IDLE);
    assign result    = result_q;
    assign carry_any = carry_any_q;
    assign neg       = neg_q;
    assign done_id   = done_id_q;

    // Next-state, operand capture, serial bit collection and slice drive
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        id_d          = id_q;
        ptr_d         = ptr_q;
        res_d         = res_q;
        cacc_d        = cacc_q;
        result_d      = result_q;
        carry_any_d   = carry_any_q;
        neg_d         = neg_q;
        done_id_d     = done_id_q;
        done          = 1'b0;
        slice_a       = 1'b0;
        slice_b       = 1'b0;
        slice_alucon0 = 1'b0;
        slice_alucon  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_grant) begin
                    a_d     = w_pick1 ? a1  : a0;
                    b_d     = w_pick1 ? b1  : b0;
                    op_d    = w_pick1 ? op1 : op0;
                    id_d    = w_pick1;
                    ptr_d   = !w_pick1;
                    k_d     = '0;
                    cacc_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                slice_a       = a_q[k_q];
                slice_b       = b_q[k_q];
                slice_alucon0 = op_q[0];
                slice_alucon  = op_q[1];
                res_d[k_q]    = slice_r;
                cacc_d        = cacc_q | slice_carry;
                if (k_q == c_K_LAST) begin
                    result_d    = res_d;
                    carry_any_d = cacc_d;
                    neg_d       = slice_n;
                    done_id_d   = id_q;
                    state_d     = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            ptr_q       <= 1'b0;
            res_q       <= '0;
            cacc_q      <= 1'b0;
            result_q    <= '0;
            carry_any_q <= 1'b0;
            neg_q       <= 1'b0;
            done_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            res_q       <= res_d;
            cacc_q      <= cacc_d;
            result_q    <= result_d;
            carry_any_q <= carry_any_d;
            neg_q       <= neg_d;
            done_id_q   <= done_id_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_arb
// Description : Self-checking bench for alu_serial_arb. A timeline model
//               (grant time, run window, done cycle, held results) predicts
//               every output each cycle; slice is modelled as R=A&B,
//               Carry=A&B, N=B.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_arb;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   op0, op1;
    logic         gnt0, gnt1, busy, done, done_id;
    logic [W-1:0] result;
    logic         carry_any, neg;
    logic         slice_a, slice_b, slice_alucon0, slice_alucon;
    logic         slice_r, slice_carry, slice_n;

    // External 1-bit slice model
    assign slice_r     = slice_a & slice_b;
    assign slice_carry = slice_a & slice_b;
    assign slice_n     = slice_b;

    alu_serial_arb #(.W(W)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .op0(op0), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
        .result(result), .carry_any(carry_any), .neg(neg),
        .slice_a(slice_a), .slice_b(slice_b),
        .slice_alucon0(slice_alucon0), .slice_alucon(slice_alucon),
        .slice_r(slice_r), .slice_carry(slice_carry), .slice_n(slice_n)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle time %0t)", tag, obs, exp, $time);
        end
    endtask

    // Stimulus state
    bit           p0, p1;          // pending (level) requests
    bit           rst_v;
    bit           hold_ops;
    bit           rand_req, rand_rst;
    logic [W-1:0] va0, vb0, va1, vb1;
    logic [1:0]   vo0, vo1;

    // Timeline model
    int           cyc     = 0;
    int           free_at = 0;     // first cycle a new grant may occur
    int           t_g     = 0;     // grant cycle of the active operation
    bit           active  = 0;
    bit           prio    = 0;     // requester favoured on a tie
    bit           owner   = 0;
    logic [W-1:0] s_a, s_b;
    logic [1:0]   s_op;
    logic [W-1:0] h_result = '0;
    bit           h_carry = 0, h_neg = 0, h_id = 0;
    bit           e_gnt0, e_gnt1;

    // One clock cycle: apply inputs, predict and check all outputs, advance model
    task automatic cycle();
        bit g_ok, win1, in_run, in_done;
        bit e_sa, e_sb, e_c0, e_c1;
        @(negedge clk);
        rst = rst_v; req0 = p0; req1 = p1;
        a0 = va0; b0 = vb0; a1 = va1; b1 = vb1; op0 = vo0; op1 = vo1;
        #1;
        g_ok    = !rst_v && (cyc >= free_at) && (p0 || p1);
        win1    = p1 && (!p0 || prio);
        e_gnt0  = g_ok && !win1;
        e_gnt1  = g_ok && win1;
        in_run  = active && (cyc >= t_g + 1) && (cyc <= t_g + W);
        in_done = active && (cyc == t_g + W + 1);
        e_sa = 0; e_sb = 0; e_c0 = 0; e_c1 = 0;
        if (in_run) begin
            e_sa = s_a[cyc - t_g - 1];
            e_sb = s_b[cyc - t_g - 1];
            e_c0 = s_op[0];
            e_c1 = s_op[1];
        end
        if (in_done) begin
            h_result = s_a & s_b;
            h_carry  = |(s_a & s_b);
            h_neg    = s_b[W-1];
            h_id     = owner;
        end
        chk("gnt0", gnt0, e_gnt0);
        chk("gnt1", gnt1, e_gnt1);
        chk("busy", busy, g_ok || in_run || in_done);
        chk("done", done, in_done);
        chk("done_id", done_id, h_id);
        chk("result", result, h_result);
        chk("carry_any", carry_any, h_carry);
        chk("neg", neg, h_neg);
        chk("slice_a", slice_a, e_sa);
        chk("slice_b", slice_b, e_sb);
        chk("slice_alucon0", slice_alucon0, e_c0);
        chk("slice_alucon", slice_alucon, e_c1);
        if (rst_v) begin
            active   = 0;
            prio     = 0;
            free_at  = cyc + 1;
            h_result = '0;
            h_carry  = 0;
            h_neg    = 0;
            h_id     = 0;
        end else if (g_ok) begin
            active  = 1;
            t_g     = cyc;
            owner   = win1;
            s_a     = win1 ? va1 : va0;
            s_b     = win1 ? vb1 : vb0;
            s_op    = win1 ? vo1 : vo0;
            prio    = !win1;
            free_at = cyc + W + 2;
        end else if (in_done) begin
            active = 0;
        end
        cyc++;
    endtask

    // Run n cycles with optional random requests, operands and resets
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            if (!hold_ops) begin
                va0 = W'($urandom); vb0 = W'($urandom);
                va1 = W'($urandom); vb1 = W'($urandom);
                vo0 = 2'($urandom); vo1 = 2'($urandom);
            end
            if (rand_req) begin
                if ($urandom_range(0, 3) == 0) p0 = 1;
                if ($urandom_range(0, 3) == 0) p1 = 1;
            end
            rst_v = rand_rst && ($urandom_range(0, 79) == 0);
            cycle();
            if (e_gnt0) p0 = 0;
            if (e_gnt1) p1 = 0;
        end
        rst_v = 0;
    endtask

    initial begin
        rst = 1; req0 = 0; req1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
        p0 = 0; p1 = 0; rst_v = 0; rand_req = 0; rand_rst = 0; hold_ops = 1;
        va0 = '0; vb0 = '0; va1 = '0; vb1 = '0; vo0 = '0; vo1 = '0;
        repeat (2) @(posedge clk);

        // Reset state, then a single AND-style operation from requester 0
        step(2);
        va0 = 8'hF0; vb0 = 8'h3C; vo0 = 2'b01; p0 = 1;
        step(11);
        chk("dir0_result", result, 8'h30);
        chk("dir0_carry", carry_any, 1'b1);
        chk("dir0_neg", neg, 1'b0);
        chk("dir0_id", done_id, 1'b0);

        // Simultaneous requests straight out of reset, then alternation
        rst_v = 1; step(1);
        p0 = 1; p1 = 1; vo1 = 2'b10;
        step(22);
        p0 = 1; p1 = 1;
        step(22);

        // Requester 1 MSB and disjoint-pattern cases
        va1 = 8'h80; vb1 = 8'h80; p1 = 1;
        step(11);
        chk("dir1_result", result, 8'h80);
        chk("dir1_carry", carry_any, 1'b1);
        chk("dir1_neg", neg, 1'b1);
        chk("dir1_id", done_id, 1'b1);
        va1 = 8'h55; vb1 = 8'hAA; p1 = 1;
        step(11);
        chk("dir2_result", result, 8'h00);
        chk("dir2_carry", carry_any, 1'b0);
        chk("dir2_neg", neg, 1'b1);

        // Reset in the middle of a run, then a normal grant
        va0 = 8'hFF; vb0 = 8'hFF; p0 = 1;
        step(5);
        rst_v = 1; step(1);
        p0 = 1;
        step(2);
        va0 = 8'h00;                // operand change after grant
        step(10);
        chk("dir3_result", result, 8'hFF);

        // Randomized traffic with operands changing every cycle
        hold_ops = 0; rand_req = 1; rand_rst = 1;
        step(1500);
        rand_rst = 0;
        step(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
